aq_spsram_arb_ctrl: RTL

AQ_SPSRAM_ARB_CTRL -- requirements
Module: aq_spsram_arb_ctrl

---
 rtl/aq_spsram_arb_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/aq_spsram_arb_ctrl.sv
// Two-requester round-robin front end for a single-port SRAM, with a full
// zero-clear sequence after reset or on request.
module aq_spsram_arb_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  clr_req,

    input  logic                  rq0_vld,
    input  logic                  rq0_wr,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    input  logic [DATA_WIDTH-1:0] rq0_bmask,
    output logic                  rq0_rdy,

    input  logic                  rq1_vld,
    input  logic                  rq1_wr,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    input  logic [DATA_WIDTH-1:0] rq1_bmask,
    output logic                  rq1_rdy,

    output logic                  rsp0_vld,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_cen,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_gwen,
    output logic [DATA_WIDTH-1:0] ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_q,

    output logic                  init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ptr;
    logic [1:0]            rsp_vld_q;
    logic                  init_done_q;
    logic                  run;
    logic                  gnt0;
    logic                  gnt1;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // ptr=0 favours requester 0; a lone requester always wins.
    assign run  = (state == RUN);
    assign gnt0 = run & rq0_vld & (~rq1_vld | ~ptr);
    assign gnt1 = run & rq1_vld & (~rq0_vld |  ptr);

    assign rq0_rdy    = gnt0;
    assign rq1_rdy    = gnt1;
    assign rsp0_vld   = rsp_vld_q[0];
    assign rsp1_vld   = rsp_vld_q[1];
    assign rsp0_rdata = rsp_vld_q[0] ? ram_q : '0;
    assign rsp1_rdata = rsp_vld_q[1] ? ram_q : '0;
    assign init_done  = init_done_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= INIT;
            clr_cnt     <= '0;
            ptr         <= 1'b0;
            rsp_vld_q   <= 2'b00;
            init_done_q <= 1'b0;
        end else begin
            rsp_vld_q <= {gnt1 & ~rq1_wr, gnt0 & ~rq0_wr};
            if (gnt0) begin
                ptr <= 1'b1;
            end else if (gnt1) begin
                ptr <= 1'b0;
            end
            case (state)
                INIT: begin
                    // Counter wraps back to zero on the last address.
                    clr_cnt <= clr_cnt + CNT_ONE;
                    if (clr_cnt == '1) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state       <= INIT;
                        init_done_q <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // SRAM is held idle while reset is asserted, whatever the state register says.
    always_comb begin
        ram_cen  = 1'b1;
        ram_a    = '0;
        ram_d    = '0;
        ram_gwen = 1'b0;
        ram_wen  = '0;
        if (cpurst_b) begin
            if (state == INIT) begin
                ram_cen  = 1'b0;
                ram_a    = clr_cnt;
                ram_gwen = 1'b1;
                ram_wen  = '1;
            end else if (gnt0) begin
                ram_cen  = 1'b0;
                ram_a    = rq0_addr;
                ram_gwen = rq0_wr;
                ram_d    = rq0_wdata;
                ram_wen  = rq0_wr ? rq0_bmask : '0;
            end else if (gnt1) begin
                ram_cen  = 1'b0;
                ram_a    = rq1_addr;
                ram_gwen = rq1_wr;
                ram_d    = rq1_wdata;
                ram_wen  = rq1_wr ? rq1_bmask : '0;
            end
        end
    end

endmodule
